// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared header for the ALU and its arbiter.
//   WORD_W    - datapath word width used by the alu
//   OP_W      - alu opcode width
//   OP_*      - alu opcode constants
//   state_t   - arbiter state encoding (IDLE / EXEC / DONE)
package alu_arbiter_pkg;

  localparam int WORD_W = 16;
  localparam int OP_W   = 5;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOT   = 5'd5;
  localparam logic [4:0] OP_SHL   = 5'd6;
  localparam logic [4:0] OP_SHR   = 5'd7;
  localparam logic [4:0] OP_PASSX = 5'd8;
  localparam logic [4:0] OP_PASSY = 5'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_arbiter_alu.sv
// alu: purely combinational word ALU shared by the arbiter.
//   op [OPW]   - opcode (OP_* from alu_arbiter_pkg); unknown opcodes give 0
//   x, y [WIDTH] - operands; shifts use the low log2(WIDTH) bits of y
//   z [WIDTH]  - result, wraps modulo 2**WIDTH, no flags
module alu
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int OPW   = OP_W
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] z
);

  localparam int SHW = $clog2(WIDTH);

  // Opcode decode and evaluation
  always_comb begin
    z = {WIDTH{1'b0}};
    case (op)
      OP_ADD:   z = x + y;
      OP_SUB:   z = x - y;
      OP_AND:   z = x & y;
      OP_OR:    z = x | y;
      OP_XOR:   z = x ^ y;
      OP_NOT:   z = ~x;
      OP_SHL:   z = x << y[SHW-1:0];
      OP_SHR:   z = x >> y[SHW-1:0];
      OP_PASSX: z = x;
      OP_PASSY: z = y;
      default:  z = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one alu between two requesters with round-robin
// arbitration and a req / gnt / ack handshake.
//   clk, reset          - clock, synchronous active-high reset
//   reqN, opN, xN, yN   - requester N request level and operation
//   gntN                - pulse in the cycle after operands were latched (EXEC)
//   ackN                - pulse in the cycle zN carries the new result (DONE)
//   zN                  - last result for requester N, held between acks
//   busy                - high while in EXEC or DONE
// All outputs are registers; none depends combinationally on a req.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int OPW   = OP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [OPW-1:0]   op0,
  input  logic [WIDTH-1:0] x0,
  input  logic [WIDTH-1:0] y0,
  output logic             gnt0,
  output logic             ack0,
  output logic [WIDTH-1:0] z0,
  input  logic             req1,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] y1,
  output logic             gnt1,
  output logic             ack1,
  output logic [WIDTH-1:0] z1,
  output logic             busy
);

  state_t           state_r;
  state_t           next_state_s;
  logic             do_grant_s;
  logic             win_s;
  logic             last_grant_r;
  logic             id_r;
  logic [OPW-1:0]   op_r;
  logic [WIDTH-1:0] x_r;
  logic [WIDTH-1:0] y_r;
  logic [WIDTH-1:0] alu_z_s;
  logic             gnt0_r;
  logic             gnt1_r;
  logic             ack0_r;
  logic             ack1_r;
  logic [WIDTH-1:0] z0_r;
  logic [WIDTH-1:0] z1_r;
  logic             busy_r;

  alu #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
    .op (op_r),
    .x  (x_r),
    .y  (y_r),
    .z  (alu_z_s)
  );

  // Next-state and arbitration decision
  always_comb begin
    next_state_s = state_r;
    do_grant_s   = 1'b0;
    win_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req0 || req1) begin
          do_grant_s   = 1'b1;
          next_state_s = ST_EXEC;
          if (req0 && req1) begin
            win_s = ~last_grant_r;
          end else begin
            win_s = req1;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        next_state_s = ST_DONE;
      end
      ST_DONE: begin
        // The requester being acked is ineligible, so only the other one
        // can be granted back-to-back.
        if ((!id_r && req1) || (id_r && req0)) begin
          do_grant_s   = 1'b1;
          win_s        = ~id_r;
          next_state_s = ST_EXEC;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
      end
    endcase
  end

  // State, handshake pulses and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      last_grant_r <= 1'b1;
      gnt0_r       <= 1'b0;
      gnt1_r       <= 1'b0;
      ack0_r       <= 1'b0;
      ack1_r       <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r <= next_state_s;
      gnt0_r  <= do_grant_s && !win_s;
      gnt1_r  <= do_grant_s && win_s;
      ack0_r  <= (state_r == ST_EXEC) && !id_r;
      ack1_r  <= (state_r == ST_EXEC) && id_r;
      busy_r  <= (next_state_s != ST_IDLE);
      if (do_grant_s) begin
        last_grant_r <= win_s;
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  // Operand register: captures the winner's operation at grant time only
  always_ff @(posedge clk) begin
    if (reset) begin
      id_r <= 1'b0;
      op_r <= {OPW{1'b0}};
      x_r  <= {WIDTH{1'b0}};
      y_r  <= {WIDTH{1'b0}};
    end else if (do_grant_s) begin
      id_r <= win_s;
      op_r <= win_s ? op1 : op0;
      x_r  <= win_s ? x1 : x0;
      y_r  <= win_s ? y1 : y0;
    end else begin
      id_r <= id_r;
      op_r <= op_r;
      x_r  <= x_r;
      y_r  <= y_r;
    end
  end

  // Result registers: written at the edge that ends EXEC
  always_ff @(posedge clk) begin
    if (reset) begin
      z0_r <= {WIDTH{1'b0}};
      z1_r <= {WIDTH{1'b0}};
    end else if (state_r == ST_EXEC) begin
      if (id_r) begin
        z1_r <= alu_z_s;
      end else begin
        z0_r <= alu_z_s;
      end
    end else begin
      z0_r <= z0_r;
      z1_r <= z1_r;
    end
  end

  assign gnt0 = gnt0_r;
  assign gnt1 = gnt1_r;
  assign ack0 = ack0_r;
  assign ack1 = ack1_r;
  assign z0   = z0_r;
  assign z1   = z1_r;
  assign busy = busy_r;

endmodule
